// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding.
package div_iter_pkg;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_SPEC = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// One quotient bit per clock over WIDTH cycles, then one sign-fixup cycle.
// Divide-by-zero and signed overflow can short-cut through a one-cycle SPEC state.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FAST_SPEC = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  // Two's-complement negation (wraps MIN_NEG onto itself).
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // Control registers
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Datapath registers
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // Combinational helpers
  logic             start_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic             spec_s;
  logic [WIDTH-1:0] dividend_abs_s;
  logic [WIDTH-1:0] divisor_abs_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             trial_neg_s;

  // Go is honoured only in IDLE and not during the done cycle itself.
  assign start_s    = (state_q == DIV_IDLE) && go && !done_q;
  assign div_zero_s = (divisor == ZERO);
  assign ovf_s      = sign && (dividend == MIN_NEG) && (divisor == ALL_ONES);
  assign spec_s     = (FAST_SPEC != 0) && (div_zero_s || ovf_s);

  assign dividend_abs_s = (sign && dividend[WIDTH-1]) ? twos_neg(dividend) : dividend;
  assign divisor_abs_s  = (sign && divisor[WIDTH-1])  ? twos_neg(divisor)  : divisor;

  // Single WIDTH+1 subtractor. Because the partial remainder is always below the
  // divisor, the top bit of the difference is exactly the "trial < 0" flag.
  assign shifted_s   = {acc_q, quo_q[WIDTH-1]};
  assign trial_s     = shifted_s - {1'b0, dvs_q};
  assign trial_neg_s = trial_s[WIDTH];

  // Next-state logic for the sequencer, iteration counter and handshake flags.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start_s) begin
          busy_d  = 1'b1;
          count_d = CNT_INIT;
          if (spec_s) begin
            state_d = DIV_SPEC;
          end else begin
            state_d = DIV_CALC;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = DIV_FIX;
        end else begin
          state_d = DIV_CALC;
        end
      end
      DIV_FIX, DIV_SPEC: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = DIV_IDLE;
        count_d = CNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Next values for operand latches, the shift/subtract datapath and the results.
  always_comb begin
    quo_d       = quo_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_s) begin
          dvs_d = divisor_abs_s;
          if (spec_s) begin
            // Final values loaded directly; no sign fixup applied afterwards.
            quo_d     = div_zero_s ? ALL_ONES : MIN_NEG;
            acc_d     = div_zero_s ? dividend : ZERO;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            quo_d     = dividend_abs_s;
            acc_d     = ZERO;
            // A zero divisor must yield all-ones regardless of operand signs, so the
            // quotient is never negated in that case.
            neg_quo_d = sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && !div_zero_s;
            neg_rem_d = sign && dividend[WIDTH-1];
          end
        end else begin
          quo_d = quo_q;
        end
      end
      DIV_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial_neg_s};
        if (trial_neg_s) begin
          acc_d = shifted_s[WIDTH-1:0];
        end else begin
          acc_d = trial_s[WIDTH-1:0];
        end
      end
      DIV_FIX, DIV_SPEC: begin
        quotient_d  = neg_quo_q ? twos_neg(quo_q) : quo_q;
        remainder_d = neg_rem_q ? twos_neg(acc_q) : acc_q;
      end
      default: begin
        quo_d = quo_q;
      end
    endcase
  end

  // Sequencer, counter and handshake registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      count_q <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q       <= ZERO;
      acc_q       <= ZERO;
      dvs_q       <= ZERO;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= ZERO;
      remainder_q <= ZERO;
    end else begin
      quo_q       <= quo_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter (WIDTH=32, FAST_SPEC=1). The driver pushes the
// expected quotient/remainder and the edge on which done must rise; a monitor
// pops and compares every time done is seen.
module tb_div_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         go;
  logic         sign;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  div_iter #(.WIDTH(W), .FAST_SPEC(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  // Edge counter: value after increment is the index of that rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no pending result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_quotient"},  quotient,  e.q);
        check({e.name, "_remainder"}, remainder, e.r);
        check({e.name, "_done_edge"}, W'(cyc),   W'(e.cyc));
      end
    end
  end

  // Issue one operation; must be called at a negedge. Leaves at the next negedge.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input bit spec, input bit expect_res, input string nm);
    exp_t e;
    go       = 1'b1;
    sign     = s;
    dividend = a;
    divisor  = b;
    if (expect_res) begin
      e.q    = eq;
      e.r    = er;
      e.cyc  = cyc + 1 + (spec ? 1 : W + 1);
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    go       = 1'b0;
    sign     = 1'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
    check({nm, "_busy_after_go"}, W'(busy), W'(1));
  endtask

  // Wait (bounded) for the done pulse; returns at the negedge where done is high.
  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({nm, "_done_seen"}, W'(seen), W'(1));
  endtask

  initial begin
    reset_n  = 1'b0;
    go       = 1'b0;
    sign     = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset_busy",      W'(busy), W'(0));
    check("reset_done",      W'(done), W'(0));
    check("reset_quotient",  quotient,  32'h0);
    check("reset_remainder", remainder, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "udiv_100_7");
    wait_done("udiv_100_7");
    @(negedge clk);
    check("done_one_cycle", W'(done), W'(0));

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1, "sdiv_m7_2");
    wait_done("sdiv_m7_2");
    @(negedge clk);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1, "sdiv_7_m2");
    wait_done("sdiv_7_m2");
    @(negedge clk);

    do_op(1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, "udiv_by0");
    wait_done("udiv_by0");
    @(negedge clk);
    do_op(1'b1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, "sdiv_by0");
    wait_done("sdiv_by0");
    @(negedge clk);
    do_op(1'b1, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b1, "sdiv_neg_by0");
    wait_done("sdiv_neg_by0");
    @(negedge clk);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 1'b1, "sdiv_ovf");
    wait_done("sdiv_ovf");
    @(negedge clk);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1, "udiv_ovf_ops");
    wait_done("udiv_ovf_ops");
    @(negedge clk);

    // Restart attempt mid-CALC must be ignored.
    do_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1, "udiv_1000_10");
    repeat (5) @(negedge clk);
    go       = 1'b1;
    sign     = 1'b1;
    dividend = 32'd55;
    divisor  = 32'd0;
    @(negedge clk);
    go = 1'b0;
    wait_done("udiv_1000_10");
    // Go held through the done cycle is ignored there and taken on the next edge.
    go       = 1'b1;
    sign     = 1'b0;
    dividend = 32'd77;
    divisor  = 32'd5;
    @(negedge clk);
    do_op(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b1, "udiv_77_5_back2back");
    wait_done("udiv_77_5_back2back");
    @(negedge clk);

    // Abort with reset around iteration 10; no result may follow.
    do_op(1'b0, 32'h0000_1234, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, "aborted");
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy",      W'(busy), W'(0));
    check("abort_done",      W'(done), W'(0));
    check("abort_quotient",  quotient,  32'h0);
    check("abort_remainder", remainder, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (W + 6) @(negedge clk);
    check("abort_busy_after", W'(busy), W'(0));

    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, "udiv_max_1");
    wait_done("udiv_max_1");
    repeat (3) @(negedge clk);

    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
